// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - Wishbone UART, 8N1, RX/TX FIFOs, programmable divisor, loopback, interrupts
// Pointers carry a wrap bit so full/empty need no extra counter.

module uart_fifo_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_pop, w_push;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rp[AW-1:0]];
  assign o_count = r_wp - r_rp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end
endmodule

module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        interrupt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             r_ack, r_rx_overrun, r_frame_err, r_tx_ovf, r_rx_s1, r_rx_s2, r_rx_push;
  logic [31:0]      r_dat;
  logic [4:0]       r_ctrl;
  logic [DIV_W-1:0] r_div, r_tx_cnt, r_tx_bdiv, r_rx_cnt, r_rx_bdiv;
  logic [2:0]       r_tx_bit, r_rx_bit;
  logic [7:0]       r_tx_shift, r_rx_shift, r_rx_byte;
  tx_state_t        r_tx_state, w_tx_nxt;
  rx_state_t        r_rx_state, w_rx_nxt;

  logic             w_req, w_wr, w_rd, w_tx_push, w_rx_pop, w_tx_pop, w_tx_end, w_tx_line;
  logic             w_rx_end, w_rx_stop_smp, w_rx_pin, w_tx_busy, w_unused;
  logic [1:0]       w_sel;
  logic [2:0]       w_w1c;
  logic [31:0]      w_status, w_rdata;
  logic [DIV_W-1:0] w_div_in, w_rx_lim;
  logic [7:0]       w_tx_rdata, w_rx_rdata;
  logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [CW-1:0]    w_rx_count, w_tx_count_unused;

  assign w_unused  = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
  // r_ack masks the held strobe so one request is acked exactly once.
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_req & wb_we_i;
  assign w_rd      = w_req & ~wb_we_i;
  assign w_sel     = wb_adr_i[3:2];
  assign w_tx_push = w_wr & (w_sel == 2'd0);
  assign w_rx_pop  = w_rd & (w_sel == 2'd0);
  assign w_w1c     = (w_wr && w_sel == 2'd1) ? wb_dat_i[7:5] : 3'b000;
  assign w_div_in  = wb_dat_i[DIV_W-1:0];
  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign uart_txd  = r_ctrl[4] | w_tx_line;
  assign w_rx_pin  = r_ctrl[4] ? w_tx_line : uart_rxd;
  assign interrupt = (r_ctrl[2] & ~w_rx_empty) | (r_ctrl[3] & w_tx_empty)
                   | r_rx_overrun | r_frame_err | r_tx_ovf;

  uart_fifo_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .i_push(w_tx_push), .i_wdata(wb_dat_i[7:0]), .i_pop(w_tx_pop),
    .o_rdata(w_tx_rdata), .o_empty(w_tx_empty), .o_full(w_tx_full), .o_count(w_tx_count_unused));

  uart_fifo_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .i_push(r_rx_push), .i_wdata(r_rx_byte), .i_pop(w_rx_pop),
    .o_rdata(w_rx_rdata), .o_empty(w_rx_empty), .o_full(w_rx_full), .o_count(w_rx_count));

  always_comb begin
    w_status       = '0;
    w_status[7:0]  = {r_tx_ovf, r_frame_err, r_rx_overrun, w_tx_busy,
                      w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
    w_status[16 +: CW] = w_rx_count;
    w_rdata = '0;
    case (w_sel)
      2'd0:    w_rdata[7:0] = w_rx_empty ? 8'h00 : w_rx_rdata;
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = 32'(r_ctrl);
      default: w_rdata = 32'(r_div);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_ctrl       <= 5'b00011;
      r_div        <= DIV_RST;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_ovf     <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr && w_sel == 2'd2) r_ctrl <= wb_dat_i[4:0];
      if (w_wr && w_sel == 2'd3) r_div <= (w_div_in < DIV_MIN) ? DIV_MIN : w_div_in;
      // Set terms are OR-ed after the clear so a coincident event is never lost.
      r_rx_overrun <= (r_rx_push & w_rx_full & ~w_rx_pop) | (r_rx_overrun & ~w_w1c[0]);
      r_frame_err  <= (w_rx_stop_smp & ~r_rx_s2) | (r_frame_err & ~w_w1c[1]);
      r_tx_ovf     <= (w_tx_push & w_tx_full & ~w_tx_pop) | (r_tx_ovf & ~w_w1c[2]);
    end
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    w_tx_pop = 1'b0;
    w_tx_end = (r_tx_cnt == r_tx_bdiv - DIV_ONE);
    w_tx_line = 1'b1;
    case (r_tx_state)
      TX_IDLE: if (r_ctrl[0] && !w_tx_empty) begin
        w_tx_nxt = TX_START;
        w_tx_pop = 1'b1;
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) w_tx_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_end && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      end
      default: if (w_tx_end) w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bdiv  <= DIV_RST;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_nxt;
      if (r_tx_state == TX_IDLE) begin
        r_tx_cnt  <= '0;
        r_tx_bdiv <= r_div;
        r_tx_bit  <= '0;
        if (w_tx_pop) r_tx_shift <= w_tx_rdata;
      end else if (w_tx_end) begin
        r_tx_cnt  <= '0;
        r_tx_bdiv <= r_div;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + DIV_ONE;
      end
    end
  end

  assign w_rx_lim      = (r_rx_state == RX_START) ? (r_rx_bdiv >> 1) : r_rx_bdiv;
  assign w_rx_end      = (r_rx_cnt == w_rx_lim - DIV_ONE);
  assign w_rx_stop_smp = (r_rx_state == RX_STOP) & w_rx_end & r_ctrl[1];

  always_comb begin
    w_rx_nxt = r_rx_state;
    if (!r_ctrl[1]) begin
      w_rx_nxt = RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE:  if (!r_rx_s2) w_rx_nxt = RX_START;
        RX_START: if (w_rx_end) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
        default:  if (w_rx_end) w_rx_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bdiv  <= DIV_RST;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_push  <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rx_s1    <= w_rx_pin;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_nxt;
      r_rx_push  <= w_rx_stop_smp & r_rx_s2;
      if (w_rx_stop_smp) r_rx_byte <= r_rx_shift;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt  <= '0;
        r_rx_bdiv <= r_div;
        r_rx_bit  <= '0;
      end else if (w_rx_end) begin
        r_rx_cnt  <= '0;
        r_rx_bdiv <= r_div;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + DIV_ONE;
      end
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - self-checking bench for uart_fifo_ctrl

module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o;
  logic        uart_rxd = 1'b1;
  logic        uart_txd, interrupt;

  int n_vec = 0;
  int n_err = 0;
  logic       bit_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  uart_fifo_ctrl dut (
    .clk(clk), .rstn(rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .interrupt(interrupt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    tick(1);
    chk("ack", wb_ack_o, 1);
    rd = wb_dat_o;
    tick(1);
    chk("ack_drop", wb_dat_o | 32'(wb_ack_o), 0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    wb_xfer(1'b1, adr, wd, d);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(1'b0, adr, 32'h0, d);
    chk(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    uart_rxd = 1'b0;
    tick(div);
    for (int j = 0; j < 8; j++) begin
      uart_rxd = b[j];
      tick(div);
    end
    uart_rxd = stop_bit;
    tick(div);
    uart_rxd = 1'b1;
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b, e;
    logic [31:0] d;
    int          t, lows;
    logic        saw_low;

    tick(3);
    chk("rst_txd", uart_txd, 1);
    chk("rst_irq", interrupt, 0);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    rstn = 1'b1;
    tick(2);
    rd_chk("rst_status", 4'h4, 32'h05);
    rd_chk("rst_ctrl", 4'h8, 32'h3);
    rd_chk("rst_div", 4'hC, 32'd434);

    wr(4'hC, 32'd1);
    rd_chk("div_clamp", 4'hC, 32'd4);
    wr(4'h8, 32'h0B);
    chk("irq_tx_empty", interrupt, 1);
    wr(4'h8, 32'h03);
    chk("irq_off", interrupt, 0);

    // Exact-cycle TX waveform for 0x55 at DIV=4
    wr(4'hC, 32'd4);
    b = 8'h55;
    for (int k = 0; k < 4; k++) bit_q.push_back(1'b0);
    for (int j = 0; j < 8; j++) for (int k = 0; k < 4; k++) bit_q.push_back(b[j]);
    for (int k = 0; k < 4; k++) bit_q.push_back(1'b1);
    wr(4'h0, 32'h55);
    while (bit_q.size() > 0) begin
      chk("tx_wave", uart_txd, bit_q.pop_front());
      tick(1);
    end
    rd_chk("tx_busy_done", 4'h4, 32'h05);

    // Loopback
    wr(4'h8, 32'h13);
    wr(4'h0, 32'hA3);
    rx_q.push_back(8'hA3);
    saw_low = 1'b0;
    repeat (60) begin
      if (uart_txd !== 1'b1) saw_low = 1'b1;
      tick(1);
    end
    chk("lb_txd_held", saw_low, 0);
    rd_chk("lb_status", 4'h4, 32'h0001_0004);
    rd_chk("lb_data", 4'h0, 32'(rx_q.pop_front()));
    rd_chk("lb_empty_rd", 4'h0, 32'h0);
    rd_chk("lb_status2", 4'h4, 32'h05);
    wr(4'h8, 32'h03);

    // RX overrun with 17 frames
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 4);
      if (i < 16) rx_q.push_back(8'(i));
    end
    tick(4);
    rd_chk("ovr_status", 4'h4, 32'h0010_0026);
    chk("ovr_irq", interrupt, 1);
    for (int i = 0; i < 16; i++) begin
      if (rx_q.size() == 0) chk("rx_sb_empty", 1, 0);
      else rd_chk("rx_data", 4'h0, 32'(rx_q.pop_front()));
    end
    wr(4'h4, 32'h20);
    rd_chk("ovr_clear", 4'h4, 32'h05);
    chk("ovr_irq_clr", interrupt, 0);

    // Framing error then glitch
    send_frame(8'h5A, 1'b0, 4);
    tick(4);
    rd_chk("ferr_status", 4'h4, 32'h45);
    wr(4'h4, 32'h40);
    wr(4'hC, 32'd8);
    uart_rxd = 1'b0;
    tick(1);
    uart_rxd = 1'b1;
    tick(30);
    rd_chk("glitch_status", 4'h4, 32'h05);

    // TX overflow, then drain
    wr(4'hC, 32'd4);
    wr(4'h8, 32'h02);
    for (int i = 0; i < 17; i++) begin
      wr(4'h0, 32'(8'h30 + i));
      if (i < 16) tx_q.push_back(8'(8'h30 + i));
    end
    rd_chk("txovf_status", 4'h4, 32'h89);
    wr(4'h4, 32'h80);
    wr(4'h8, 32'h03);
    for (int f = 0; f < 16; f++) begin
      t = 0;
      while (uart_txd !== 1'b0 && t < 200) begin
        tick(1);
        t++;
      end
      if (t >= 200) begin
        chk("tx_start_timeout", 1, 0);
        break;
      end
      tick(2);
      b = '0;
      for (int j = 0; j < 8; j++) begin
        tick(4);
        b[j] = uart_txd;
      end
      tick(4);
      chk("tx_stop", uart_txd, 1);
      e = tx_q.pop_front();
      chk("tx_byte", b, e);
      tick(2);
    end
    lows = 0;
    repeat (100) begin
      if (uart_txd === 1'b0) lows++;
      tick(1);
    end
    chk("tx_no_extra", lows, 0);
    rd_chk("tx_drained", 4'h4, 32'h05);

    // Reset mid-frame
    wr(4'h0, 32'h00);
    chk("midframe_start", uart_txd, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_txd", uart_txd, 1);
    tick(2);
    rstn = 1'b1;
    tick(1);
    rd_chk("post_rst_status", 4'h4, 32'h05);
    rd_chk("post_rst_ctrl", 4'h8, 32'h3);
    rd_chk("post_rst_div", 4'hC, 32'd434);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Parametrised UART controller with Wishbone-slave register access, RX/TX FIFOs of configurable depth, a runtime-programmable baud divisor, internal loopback and maskable interrupts. It sits on the core's Wishbone peripheral bus in place of a fixed-configuration UART. It drives the board-level TX/RX pins directly. Frame format is fixed 8N1, LSB first.

## Interface
- FIFO_DEPTH, 16: entries per FIFO; power of two, ≥2.
- DIV_W, 16: width of the baud divisor register.
- DEFAULT_DIV, 434: reset divisor in clocks per bit (50 MHz / 115200).
- clk  in  1  sole clock.
- rstn  in  1  reset; asynchronous, active-low.
- wb_adr_i  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1, 0 otherwise.
- wb_we_i  in  1  write enable.
- wb_stb_i, wb_cyc_i  in  1 each  strobe and cycle; a request is stb&cyc.
- wb_sel_i  in  4  byte select; ignored, full-word access only.
- wb_ack_o  out  1  single-cycle acknowledge.
- uart_rxd  in  1  serial input, asynchronous to clk.
- uart_txd  out  1  serial output, idles high.
- interrupt  out  1  level interrupt request.

## Operation
- **Register map:**
  - 0x0 DATA: a write pushes wb_dat_i[7:0] into the TX FIFO. A read pops the RX FIFO and returns the byte in [7:0]; an empty read returns 0 and has no effect.
  - 0x4 STATUS:
    - b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 tx_busy (TX FSM not IDLE).
    - b5 rx_overrun, b6 frame_err, b7 tx_overflow: sticky, write-1-to-clear.
    - [23:16] RX FIFO count.
  - 0x8 CTRL (RW): b0 tx_en, b1 rx_en, b2 rx_irq_en, b3 tx_irq_en, b4 loopback. Reset value 0x3.
  - 0xC DIV (RW): [DIV_W-1:0] clocks per bit. Written values below 4 are stored as 4. Reset value DEFAULT_DIV.
- **FIFO write side:** a DATA write with the TX FIFO full drops the byte and sets tx_overflow.
- **interrupt** = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | rx_overrun | frame_err | tx_overflow.
- **TX FSM** (IDLE, START, DATA, STOP):
  - IDLE→START when tx_en=1 and the TX FIFO is non-empty. The FIFO is popped on this transition.
  - Each state lasts DIV cycles. DATA shifts 8 bits, LSB first. STOP drives 1, then returns to IDLE.
  - Clearing tx_en mid-frame lets the current frame complete.
- **RX path:**
  - uart_rxd passes through a 2-flop synchroniser.
  - IDLE: on a low level, go to START.
  - START: wait DIV/2 cycles (integer division). If the line is still low, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample every DIV cycles (mid-bit), 8 bits.
  - STOP: sample once, then return to IDLE. If the sample is high and the RX FIFO is not full, push the byte. If the FIFO is full, discard the byte and set rx_overrun. If the sample is low, discard the byte and set frame_err.
  - Clearing rx_en forces the RX FSM to IDLE immediately.
- **Loopback=1:** the RX input is taken from the internal TX serial output, uart_txd is held at 1, and uart_rxd is ignored.
- **DIV changes** take effect at the next bit boundary.

## Timing
- **Reset values:** wb_ack_o=0, wb_dat_o=0, uart_txd=1, interrupt=0. Both FIFOs empty, both FSMs IDLE, sticky bits 0.
- **Reset mid-frame:** uart_txd goes high asynchronously and the partial RX byte is lost.
- **Wishbone handshake:**
  - A request in cycle N produces wb_ack_o=1 in cycle N+1, for one cycle only.
  - If stb&cyc is still high at N+1, that is the same transaction and is not re-acked. The next request is sampled at N+2 at the earliest.
  - The register side effect (push, pop, W1C, CTRL/DIV write) happens once, at the clock edge ending cycle N.
- **TX latency:** for a DATA write acked in cycle N+1 with TX idle and tx_en=1, uart_txd falls at cycle N+2. The frame lasts 10×DIV cycles.
- **RX latency:** a byte becomes visible (rx_empty=0) 2 cycles after the mid-stop-bit sample.
- **Simultaneous RX push and pop on a full FIFO:** the pop is applied first, so the push succeeds and no overrun is flagged.
- **Simultaneous TX pop and push on a full FIFO:** the push succeeds and no overflow is flagged.
- **Simultaneous W1C and set of a sticky bit:** set wins.
- **Pointers:** log2(FIFO_DEPTH)+1 bits with a wrap bit. Full when indices are equal and wrap bits differ.

## Test plan
- Reset, DIV=4, write DATA=0x55 → uart_txd from cycle 2 after the ack: 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each held 4 cycles; tx_busy falls 40 cycles after the frame starts.
- Loopback=1, DIV=4, write 0xA3 → after the frame, STATUS[23:16]=1 and a DATA read returns 0xA3; the second read returns 0 with rx_empty=1.
- Drive 17 frames into uart_rxd (FIFO_DEPTH=16) without reading → rx_full=1, rx_overrun=1, interrupt=1; 16 reads return bytes 0..15 in order; write STATUS=0x20 clears rx_overrun.
- Drive a frame with stop bit 0 → frame_err=1, RX count stays 0. Drive a 1-cycle low glitch (DIV=8) → no byte pushed and no error flagged.
- Write 17 bytes with tx_en=0 → tx_full=1, tx_overflow=1. Set tx_en → exactly 16 frames are transmitted, then tx_empty=1.
- Assert rstn=0 mid-TX-frame → uart_txd=1 asynchronously. After release: STATUS=0x05, CTRL=0x3, DIV=434.
